// File: rtl/mem_pkg.sv
// Shared load/store definitions: access-size encodings, access-unit FSM states,
// lane masks and the alignment rule used by both the access unit and decode.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    ST_ERR,
    ST_RESP
  } state_e;

  localparam logic [31:0] LANE_BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] LANE_HALF_MASK = 32'h0000_FFFF;

  // Reserved size is aligned like a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a bus word,
// and merges a byte/halfword store into a previously read word.
module mau_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        sgn,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic s);
    logic signed [7:0] sv;
    sv = signed'(v);
    return s ? 32'(sv) : {24'b0, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic s);
    logic signed [15:0] sv;
    sv = signed'(v);
    return s ? 32'(sv) : {16'b0, v};
  endfunction

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  bv;
  logic [15:0] hv;
  logic [31:0] bmask;
  logic [31:0] hmask;

  assign bsh   = {off, 3'b000};
  assign hsh   = {off[1], 4'b0000};
  assign bv    = 8'(word >> bsh);
  assign hv    = off[1] ? word[31:16] : word[15:0];
  assign bmask = LANE_BYTE_MASK << bsh;
  assign hmask = LANE_HALF_MASK << hsh;

  always_comb begin
    load_val = word;
    merged   = wdata;
    case (size)
      SZ_BYTE: begin
        load_val = ext8(bv, sgn);
        merged   = (word & ~bmask) | ((wdata & LANE_BYTE_MASK) << bsh);
      end
      SZ_HALF: begin
        load_val = ext16(hv, sgn);
        merged   = (word & ~hmask) | ((wdata & LANE_HALF_MASK) << hsh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: one byte-addressed request at a time, turned into
// word-wide bus cycles with read-modify-write for sub-word stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addressVirt,
  output logic [31:0] dataInVirt,
  output logic        wEnVirt,
  input  logic [31:0] dataOutVirt
);

  // Loads sample the bus on the cycle read data is valid; sub-word stores
  // leave READ one cycle earlier so MERGE itself sees the valid read word.
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY);
  localparam logic [1:0] LAT_PRE  = 2'(READ_LATENCY - 1);

  state_e      state, state_nxt;
  logic [1:0]  cnt;
  logic        we_r;
  logic        sgn_r;
  size_e       size_r;
  logic [1:0]  off_r;
  logic [31:0] wdata_r;

  logic        accept;
  logic        mis;
  size_e       size_in;
  logic        word_sz;
  logic        rd_done;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept  = req_valid & req_ready;
  assign mis     = misaligned(req_size, req_addr[1:0]);
  assign size_in = (req_size == SZ_RSVD) ? SZ_WORD : size_e'(req_size);
  assign word_sz = (size_in == SZ_WORD);
  assign rd_done = (state == ST_READ) && !we_r && (cnt == LAT_LAST);

  mau_lane_align u_align (
    .word     (dataOutVirt),
    .wdata    (wdata_r),
    .off      (off_r),
    .size     (size_r),
    .sgn      (sgn_r),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ST_READ) ? cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (mis)                  state_nxt = ST_ERR;
          else if (req_we && word_sz) state_nxt = ST_WRITE;
          else                      state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (we_r) begin
          if (cnt == LAT_PRE) state_nxt = ST_MERGE;
        end else if (cnt == LAT_LAST) begin
          state_nxt = ST_RESP;
        end
      end
      ST_MERGE: state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_RESP;
      ST_ERR:   state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    wEnVirt    = 1'b0;
    case (state)
      ST_IDLE:  req_ready  = 1'b1;
      ST_WRITE: wEnVirt    = 1'b1;
      ST_RESP:  resp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_r    <= req_we;
      sgn_r   <= req_signed;
      size_r  <= size_in;
      off_r   <= req_addr[1:0];
      wdata_r <= req_wdata;
    end
  end

  // Bus-facing and response registers; a misaligned access leaves the bus untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      addressVirt <= '0;
      dataInVirt  <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        resp_err   <= mis;
        resp_rdata <= '0;
        if (!mis) addressVirt <= {2'b00, req_addr[31:2]};
        if (!mis && req_we && word_sz) dataInVirt <= req_wdata;
      end
      if (rd_done) resp_rdata <= load_val;
      if (state == ST_MERGE) dataInVirt <= merged;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: two instances (read latency 1 and 3),
// each backed by a small synchronous word memory.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    int          s;
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          wp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tb_init;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  int          sel = 0;

  logic [1:0]        rv, rdy, resp_v, err, wen;
  logic [1:0][31:0]  rdata, av, din, dout;
  logic [31:0]       mem [2][64];
  logic [5:0]        ap  [2][3];
  int                wcnt [2];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_av [2];
  vec_t        vt[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign rv[g] = req_valid && (sel == g);
    mem_access_unit #(.READ_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (rv[g]),
      .req_ready   (rdy[g]),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_signed  (req_signed),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_v[g]),
      .resp_rdata  (rdata[g]),
      .resp_err    (err[g]),
      .addressVirt (av[g]),
      .dataInVirt  (din[g]),
      .wEnVirt     (wen[g]),
      .dataOutVirt (dout[g])
    );
  end

  // Synchronous memories: data for an address appears READ_LATENCY cycles later.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (tb_init) wcnt[g] <= 0;
      else if (wen[g]) wcnt[g] <= wcnt[g] + 1;
      if (wen[g]) mem[g][av[g][5:0]] <= din[g];
      ap[g][2] <= ap[g][1];
      ap[g][1] <= ap[g][0];
      ap[g][0] <= av[g][5:0];
    end
  end
  assign dout[0] = mem[0][ap[0][0]];
  assign dout[1] = mem[1][ap[1][2]];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int s, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input logic e, input int lat, input int wp);
    vec_t v;
    v.s = s; v.we = we; v.sz = sz; v.sg = sg; v.addr = a; v.wd = wd;
    v.rd = rd; v.err = e; v.lat = lat; v.wp = wp;
    vt.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int          lat, busy_bad, w0, k;
    logic [31:0] rd, exp_av;
    logic        e;
    sel = v.s;
    k = 0;
    while (!rdy[v.s] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d ready", i), 32'(rdy[v.s]), 32'd1);
    exp_av = v.err ? last_av[v.s] : {2'b00, v.addr[31:2]};
    w0 = wcnt[v.s];
    req_valid = 1'b1; req_we = v.we; req_size = v.sz; req_signed = v.sg;
    req_addr = v.addr; req_wdata = v.wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~v.we; req_size = 2'b00; req_signed = ~v.sg;
    req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5A5A_5A5A;
    lat = -1; busy_bad = 0; rd = 'x; e = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (rdy[v.s]) busy_bad++;
      if (av[v.s] !== exp_av) busy_bad++;
      if (resp_v[v.s]) begin
        lat = c; rd = rdata[v.s]; e = err[v.s];
        break;
      end
    end
    chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d rdata", i), rd, v.rd);
    chk($sformatf("v%0d err", i), 32'(e), 32'(v.err));
    chk($sformatf("v%0d busy/addr", i), 32'(busy_bad), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d pulse", i), 32'(resp_v[v.s]), 32'd0);
    chk($sformatf("v%0d writes", i), 32'(wcnt[v.s] - w0), 32'(v.wp));
    last_av[v.s] = exp_av;
  endtask

  task automatic b2b(input int s, input logic [31:0] addrs [4], input logic [31:0] exps [4]);
    int   issued, got, bad, extra;
    logic prev;
    sel = s; issued = 0; got = 0; bad = 0; extra = 0;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_valid = 1'b1; req_addr = addrs[0];
    prev = rdy[s];
    for (int c = 0; c < 80 && got < 4; c++) begin
      @(negedge clk);
      if (prev) issued++;
      if (rdy[s] && issued > got) bad++;
      if (resp_v[s]) begin
        chk($sformatf("b2b%0d resp%0d", s, got), rdata[s], exps[got]);
        got++;
      end
      if (issued < 4) begin
        req_valid = 1'b1;
        req_addr = addrs[issued];
      end else begin
        req_valid = 1'b0;
      end
      prev = rdy[s] && req_valid;
    end
    req_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_v[s]) extra++;
    end
    chk($sformatf("b2b%0d count", s), 32'(got), 32'd4);
    chk($sformatf("b2b%0d extra", s), 32'(extra), 32'd0);
    chk($sformatf("b2b%0d ready-busy", s), 32'(bad), 32'd0);
    last_av[s] = {2'b00, addrs[3][31:2]};
  endtask

  initial begin
    logic [31:0] a4 [4];
    logic [31:0] e4 [4];
    int w0, seen;

    rst = 1'b1; tb_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    last_av[0] = '0; last_av[1] = '0;

    //  s we  size   sg  addr      wdata         rdata         err lat wp
    add(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h00000000, 0, 2, 1);
    add(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 0);
    add(0, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h00000000, 0, 2, 1);
    add(0, 1, 2'b00, 0, 32'h13, 32'h123456AA, 32'h00000000, 0, 4, 1);
    add(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hAA223344, 0, 3, 0);
    add(0, 0, 2'b00, 1, 32'h13, 32'h0,        32'hFFFFFFAA, 0, 3, 0);
    add(0, 0, 2'b00, 0, 32'h13, 32'h0,        32'h000000AA, 0, 3, 0);
    add(0, 0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFFAA22, 0, 3, 0);
    add(0, 0, 2'b01, 0, 32'h10, 32'h0,        32'h00003344, 0, 3, 0);
    add(0, 0, 2'b00, 1, 32'h11, 32'h0,        32'h00000033, 0, 3, 0);
    add(0, 1, 2'b10, 0, 32'h14, 32'hCAFEF00D, 32'h00000000, 0, 2, 1);
    add(0, 1, 2'b01, 0, 32'h16, 32'h9999BEEF, 32'h00000000, 0, 4, 1);
    add(0, 1, 2'b00, 0, 32'h14, 32'h00000011, 32'h00000000, 0, 4, 1);
    add(0, 0, 2'b10, 0, 32'h14, 32'h0,        32'hBEEFF011, 0, 3, 0);
    add(0, 0, 2'b01, 1, 32'h14, 32'h0,        32'hFFFFF011, 0, 3, 0);
    add(0, 0, 2'b10, 0, 32'h06, 32'h0,        32'h00000000, 1, 2, 0);
    add(0, 1, 2'b01, 0, 32'h11, 32'h0000FFFF, 32'h00000000, 1, 2, 0);
    add(0, 1, 2'b11, 0, 32'h18, 32'h01020304, 32'h00000000, 0, 2, 1);
    add(0, 0, 2'b00, 0, 32'h1B, 32'h0,        32'h00000001, 0, 3, 0);
    add(0, 0, 2'b11, 0, 32'h18, 32'h0,        32'h01020304, 0, 3, 0);
    add(0, 0, 2'b11, 0, 32'h1A, 32'h0,        32'h00000000, 1, 2, 0);
    add(0, 1, 2'b10, 0, 32'h12, 32'h77777777, 32'h00000000, 1, 2, 0);
    add(1, 1, 2'b10, 0, 32'h10, 32'h80706050, 32'h00000000, 0, 2, 1);
    add(1, 0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFF8070, 0, 5, 0);
    add(1, 1, 2'b00, 0, 32'h10, 32'h0000007F, 32'h00000000, 0, 6, 1);
    add(1, 0, 2'b10, 0, 32'h10, 32'h0,        32'h8070607F, 0, 5, 0);
    add(1, 0, 2'b00, 1, 32'h11, 32'h0,        32'h00000060, 0, 5, 0);
    add(1, 1, 2'b10, 0, 32'h14, 32'h0BADC0DE, 32'h00000000, 0, 2, 1);
    add(1, 1, 2'b10, 0, 32'h18, 32'h13579BDF, 32'h00000000, 0, 2, 1);
    add(1, 0, 2'b00, 1, 32'h1B, 32'h0,        32'h00000013, 0, 5, 0);
    add(1, 0, 2'b10, 0, 32'h05, 32'h0,        32'h00000000, 1, 2, 0);

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset%0d req_ready", g), 32'(rdy[g]), 32'd1);
      chk($sformatf("reset%0d resp_valid", g), 32'(resp_v[g]), 32'd0);
      chk($sformatf("reset%0d resp_rdata", g), rdata[g], 32'd0);
      chk($sformatf("reset%0d resp_err", g), 32'(err[g]), 32'd0);
      chk($sformatf("reset%0d wEnVirt", g), 32'(wen[g]), 32'd0);
      chk($sformatf("reset%0d addressVirt", g), av[g], 32'd0);
      chk($sformatf("reset%0d dataInVirt", g), din[g], 32'd0);
    end
    tb_init = 1'b0;
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i], i);

    // Request presented while reset is high must be ignored.
    sel = 0;
    w0 = wcnt[0];
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h3C; req_wdata = 32'h12345678;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_v[0]) seen++;
    end
    chk("rst+valid no resp", 32'(seen), 32'd0);
    chk("rst+valid no write", 32'(wcnt[0] - w0), 32'd0);
    chk("rst+valid ready", 32'(rdy[0]), 32'd1);
    chk("rst+valid addr", av[0], 32'd0);
    last_av[0] = '0;

    // Reset held two cycles in the middle of a latency-3 load.
    sel = 1;
    w0 = wcnt[1];
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_v[1]) seen++;
    end
    chk("midread no resp", 32'(seen), 32'd0);
    chk("midread ready", 32'(rdy[1]), 32'd1);
    chk("midread wEnVirt", 32'(wen[1]), 32'd0);
    chk("midread no write", 32'(wcnt[1] - w0), 32'd0);
    chk("midread rdata", rdata[1], 32'd0);
    chk("midread err", 32'(err[1]), 32'd0);
    last_av[1] = '0;

    a4[0] = 32'h10; a4[1] = 32'h14; a4[2] = 32'h18; a4[3] = 32'h10;
    e4[0] = 32'hAA223344; e4[1] = 32'hBEEFF011; e4[2] = 32'h01020304; e4[3] = 32'hAA223344;
    b2b(0, a4, e4);
    a4[3] = 32'h14;
    e4[0] = 32'h8070607F; e4[1] = 32'h0BADC0DE; e4[2] = 32'h13579BDF; e4[3] = 32'h0BADC0DE;
    b2b(1, a4, e4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
